// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory pipeline stage that sits directly upstream of writeback.
//   - Accepts one instruction per cycle from execute while idle.
//   - Instructions with no memory operation retire one cycle after acceptance.
//   - Loads and stores go out over a req/ack data-memory handshake. Execute is
//     stalled for the whole access. If no ack arrives in time, the access is
//     abandoned with a one-cycle bus_error pulse.
//   - Writeback enable, address and data are registered. Register r0 is
//     hard-wired to zero, so it never receives a write pulse.
//
// Ports
//   gclk_i, reset_i           clock (rising edge); synchronous active-high reset
//   ex_valid_i                execute presents an instruction this cycle
//   ex_alu_result_i           ALU result, also used as the memory address
//   ex_store_data_i           store data
//   ex_mem_read_i             instruction is a load
//   ex_mem_write_i            instruction is a store (wins over read)
//   ex_wb_enable_i            instruction writes a register
//   ex_wb_addr_i              destination register
//   mem_stall_o               execute must hold its ex_* outputs
//   dmem_req_o/we_o           memory request / 1 = write
//   dmem_addr_o/wdata_o       memory address / write data
//   dmem_rdata_i/ack_i        read data, valid together with ack
//   wb_enable_o               one-cycle register write pulse
//   wb_addr_o/wb_data_o       register write address / data
//   bus_error_o               one-cycle pulse on access timeout
// -----------------------------------------------------------------------------
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  ST_IDLE   | accepting instructions from execute; dmem_ack is ignored
//  ST_ACCESS | memory request outstanding; execute stalled; timeout counting
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int WORD_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                      gclk_i,
    input  logic                      reset_i,
    input  logic                      ex_valid_i,
    input  logic [WORD_WIDTH-1:0]     ex_alu_result_i,
    input  logic [WORD_WIDTH-1:0]     ex_store_data_i,
    input  logic                      ex_mem_read_i,
    input  logic                      ex_mem_write_i,
    input  logic                      ex_wb_enable_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_wb_addr_i,
    output logic                      mem_stall_o,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [WORD_WIDTH-1:0]     dmem_addr_o,
    output logic [WORD_WIDTH-1:0]     dmem_wdata_o,
    input  logic [WORD_WIDTH-1:0]     dmem_rdata_i,
    input  logic                      dmem_ack_i,
    output logic                      wb_enable_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [WORD_WIDTH-1:0]     wb_data_o,
    output logic                      bus_error_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0]      CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    state_e                    state_q, state_d;
    logic                      mem_stall_q, mem_stall_d;
    logic                      dmem_req_q, dmem_req_d;
    logic                      dmem_we_q, dmem_we_d;
    logic [WORD_WIDTH-1:0]     dmem_addr_q, dmem_addr_d;
    logic [WORD_WIDTH-1:0]     dmem_wdata_q, dmem_wdata_d;
    logic                      wb_enable_q, wb_enable_d;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [WORD_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic                      bus_error_q, bus_error_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    // Writeback fields of the instruction whose memory access is in flight.
    logic                      pend_wb_en_q, pend_wb_en_d;
    logic [REG_ADDR_WIDTH-1:0] pend_wb_addr_q, pend_wb_addr_d;

    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        wb_enable_d    = 1'b0;
        wb_addr_d      = wb_addr_q;
        wb_data_d      = wb_data_q;
        bus_error_d    = 1'b0;
        cnt_d          = cnt_q;
        pend_wb_en_d   = pend_wb_en_q;
        pend_wb_addr_d = pend_wb_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i) begin
                    if (ex_mem_read_i || ex_mem_write_i) begin
                        state_d        = ST_ACCESS;
                        dmem_req_d     = 1'b1;
                        // A read+write combination is issued as a store.
                        dmem_we_d      = ex_mem_write_i;
                        dmem_addr_d    = ex_alu_result_i;
                        dmem_wdata_d   = ex_store_data_i;
                        cnt_d          = '0;
                        pend_wb_en_d   = ex_wb_enable_i;
                        pend_wb_addr_d = ex_wb_addr_i;
                    end else begin
                        wb_enable_d = ex_wb_enable_i && (ex_wb_addr_i != REG_ZERO);
                        wb_addr_d   = ex_wb_addr_i;
                        wb_data_d   = ex_alu_result_i;
                    end
                end
            end

            ST_ACCESS: begin
                // Ack takes priority over the timeout on the last allowed cycle.
                if (dmem_ack_i) begin
                    state_d    = ST_IDLE;
                    dmem_req_d = 1'b0;
                    cnt_d      = '0;
                    if (!dmem_we_q) begin
                        wb_enable_d = pend_wb_en_q && (pend_wb_addr_q != REG_ZERO);
                        wb_addr_d   = pend_wb_addr_q;
                        wb_data_d   = dmem_rdata_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    dmem_req_d  = 1'b0;
                    bus_error_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                dmem_req_d = 1'b0;
                cnt_d      = '0;
            end
        endcase

        mem_stall_d = (state_d == ST_ACCESS);
    end

    always_ff @(posedge gclk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            mem_stall_q    <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            wb_enable_q    <= 1'b0;
            wb_addr_q      <= '0;
            wb_data_q      <= '0;
            bus_error_q    <= 1'b0;
            cnt_q          <= '0;
            pend_wb_en_q   <= 1'b0;
            pend_wb_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            mem_stall_q    <= mem_stall_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            wb_enable_q    <= wb_enable_d;
            wb_addr_q      <= wb_addr_d;
            wb_data_q      <= wb_data_d;
            bus_error_q    <= bus_error_d;
            cnt_q          <= cnt_d;
            pend_wb_en_q   <= pend_wb_en_d;
            pend_wb_addr_q <= pend_wb_addr_d;
        end
    end

    assign mem_stall_o  = mem_stall_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign wb_enable_o  = wb_enable_q;
    assign wb_addr_o    = wb_addr_q;
    assign wb_data_o    = wb_data_q;
    assign bus_error_o  = bus_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    localparam int W  = 16;
    localparam int A  = 3;
    localparam int TO = 15;

    logic          gclk = 1'b0;
    logic          reset_i;
    logic          ex_valid_i;
    logic [W-1:0]  ex_alu_result_i;
    logic [W-1:0]  ex_store_data_i;
    logic          ex_mem_read_i;
    logic          ex_mem_write_i;
    logic          ex_wb_enable_i;
    logic [A-1:0]  ex_wb_addr_i;
    logic          mem_stall_o;
    logic          dmem_req_o;
    logic          dmem_we_o;
    logic [W-1:0]  dmem_addr_o;
    logic [W-1:0]  dmem_wdata_o;
    logic [W-1:0]  dmem_rdata_i;
    logic          dmem_ack_i;
    logic          wb_enable_o;
    logic [A-1:0]  wb_addr_o;
    logic [W-1:0]  wb_data_o;
    logic          bus_error_o;

    always #5 gclk = ~gclk;

    mem_access_stage #(
        .WORD_WIDTH    (W),
        .REG_ADDR_WIDTH(A),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (4)
    ) dut (
        .gclk_i         (gclk),
        .reset_i        (reset_i),
        .ex_valid_i     (ex_valid_i),
        .ex_alu_result_i(ex_alu_result_i),
        .ex_store_data_i(ex_store_data_i),
        .ex_mem_read_i  (ex_mem_read_i),
        .ex_mem_write_i (ex_mem_write_i),
        .ex_wb_enable_i (ex_wb_enable_i),
        .ex_wb_addr_i   (ex_wb_addr_i),
        .mem_stall_o    (mem_stall_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_ack_i     (dmem_ack_i),
        .wb_enable_o    (wb_enable_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o),
        .bus_error_o    (bus_error_o)
    );

    typedef struct {
        logic         is_err;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_wb(input logic [A-1:0] a, input logic [W-1:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.addr   = a;
        e.data   = d;
        sb_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.addr   = '0;
        e.data   = '0;
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer: every writeback pulse or bus error must match the
    // oldest expected event.
    always @(negedge gclk) begin
        if (wb_enable_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("wb_unexpected", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("wb_kind", {31'd0, mon_e.is_err}, 0);
                check_eq("wb_addr", wb_addr_o, mon_e.addr);
                check_eq("wb_data", wb_data_o, mon_e.data);
            end
        end
        if (bus_error_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("berr_unexpected", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("berr_kind", {31'd0, mon_e.is_err}, 1);
            end
        end
    end

    task automatic tick();
        @(negedge gclk);
    endtask

    task automatic drive_nop();
        ex_valid_i      = 1'b0;
        ex_mem_read_i   = 1'b0;
        ex_mem_write_i  = 1'b0;
        ex_wb_enable_i  = 1'b0;
        ex_wb_addr_i    = '0;
        ex_alu_result_i = '0;
        ex_store_data_i = '0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic wben,
                         input logic [A-1:0] wa, input logic [W-1:0] alu,
                         input logic [W-1:0] sd);
        ex_valid_i      = 1'b1;
        ex_mem_read_i   = rd;
        ex_mem_write_i  = wr;
        ex_wb_enable_i  = wben;
        ex_wb_addr_i    = wa;
        ex_alu_result_i = alu;
        ex_store_data_i = sd;
    endtask

    initial begin
        int           req_cycles;
        logic [W-1:0] rnd;

        reset_i      = 1'b1;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
        drive_nop();
        repeat (2) tick();

        check_eq("rst_stall", mem_stall_o, 0);
        check_eq("rst_req",   dmem_req_o, 0);
        check_eq("rst_we",    dmem_we_o, 0);
        check_eq("rst_addr",  dmem_addr_o, 0);
        check_eq("rst_wdata", dmem_wdata_o, 0);
        check_eq("rst_wb_en", wb_enable_o, 0);
        check_eq("rst_wb_a",  wb_addr_o, 0);
        check_eq("rst_wb_d",  wb_data_o, 0);
        check_eq("rst_berr",  bus_error_o, 0);
        reset_i = 1'b0;
        tick();

        // ALU op, latency 1
        issue(1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 16'h0);
        push_wb(3'd3, 16'h1234);
        tick();
        drive_nop();
        check_eq("t1_wb_en", wb_enable_o, 1);
        check_eq("t1_stall", mem_stall_o, 0);
        tick();
        check_eq("t1_pulse", wb_enable_o, 0);

        // Load with ack in the third request cycle; next instruction held by execute
        issue(1'b1, 1'b0, 1'b1, 3'd5, 16'h0040, 16'h0);
        push_wb(3'd5, 16'hBEEF);
        tick();
        issue(1'b0, 1'b0, 1'b1, 3'd2, 16'h7777, 16'h0);
        push_wb(3'd2, 16'h7777);
        for (int i = 1; i <= 3; i++) begin
            check_eq("t2_req",   dmem_req_o, 1);
            check_eq("t2_addr",  dmem_addr_o, 16'h0040);
            check_eq("t2_we",    dmem_we_o, 0);
            check_eq("t2_stall", mem_stall_o, 1);
            check_eq("t2_no_wb", wb_enable_o, 0);
            if (i == 3) begin
                dmem_ack_i   = 1'b1;
                dmem_rdata_i = 16'hBEEF;
            end
            tick();
        end
        dmem_ack_i = 1'b0;
        check_eq("t2_req_done", dmem_req_o, 0);
        check_eq("t2_stall_done", mem_stall_o, 0);
        check_eq("t2_wb_en", wb_enable_o, 1);
        check_eq("t2_wb_a", wb_addr_o, 3'd5);
        tick();
        drive_nop();
        check_eq("t2_held_wb_en", wb_enable_o, 1);
        check_eq("t2_held_wb_a", wb_addr_o, 3'd2);
        tick();
        check_eq("t2_pulse", wb_enable_o, 0);

        // Store, ack in the first request cycle
        issue(1'b0, 1'b1, 1'b1, 3'd4, 16'h0010, 16'hA5A5);
        tick();
        drive_nop();
        check_eq("t3_req",   dmem_req_o, 1);
        check_eq("t3_we",    dmem_we_o, 1);
        check_eq("t3_addr",  dmem_addr_o, 16'h0010);
        check_eq("t3_wdata", dmem_wdata_o, 16'hA5A5);
        check_eq("t3_stall", mem_stall_o, 1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'h1111;
        tick();
        dmem_ack_i = 1'b0;
        check_eq("t3_req_done", dmem_req_o, 0);
        check_eq("t3_stall_done", mem_stall_o, 0);
        check_eq("t3_no_wb", wb_enable_o, 0);
        tick();

        // Read and write together behaves as a store
        issue(1'b1, 1'b1, 1'b1, 3'd4, 16'h0020, 16'h5A5A);
        tick();
        drive_nop();
        check_eq("t3b_we", dmem_we_o, 1);
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        check_eq("t3b_no_wb", wb_enable_o, 0);
        tick();

        // Load timeout
        issue(1'b1, 1'b0, 1'b1, 3'd6, 16'h0080, 16'h0);
        push_err();
        tick();
        drive_nop();
        req_cycles = 0;
        for (int i = 0; i < TO; i++) begin
            if (dmem_req_o === 1'b1) req_cycles++;
            tick();
        end
        check_eq("t4_req_cycles", req_cycles, TO);
        check_eq("t4_req_done", dmem_req_o, 0);
        check_eq("t4_berr", bus_error_o, 1);
        check_eq("t4_no_wb", wb_enable_o, 0);
        check_eq("t4_stall", mem_stall_o, 0);
        tick();
        check_eq("t4_berr_pulse", bus_error_o, 0);

        // Ack on the timeout cycle wins
        issue(1'b1, 1'b0, 1'b1, 3'd7, 16'h0090, 16'h0);
        push_wb(3'd7, 16'hC0DE);
        tick();
        drive_nop();
        repeat (TO - 1) tick();
        check_eq("t4b_req_last", dmem_req_o, 1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'hC0DE;
        tick();
        dmem_ack_i = 1'b0;
        check_eq("t4b_req_done", dmem_req_o, 0);
        check_eq("t4b_no_berr", bus_error_o, 0);
        check_eq("t4b_wb_en", wb_enable_o, 1);
        tick();

        // Write to r0 and a spurious ack while idle
        issue(1'b0, 1'b0, 1'b1, 3'd0, 16'hDEAD, 16'h0);
        tick();
        drive_nop();
        check_eq("t5_r0_wb_en", wb_enable_o, 0);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'hFFFF;
        tick();
        dmem_ack_i = 1'b0;
        check_eq("t5_spur_req", dmem_req_o, 0);
        check_eq("t5_spur_stall", mem_stall_o, 0);
        check_eq("t5_spur_wb", wb_enable_o, 0);
        tick();
        check_eq("t5_spur_req2", dmem_req_o, 0);

        // Reset during a load, then a late ack
        issue(1'b1, 1'b0, 1'b1, 3'd1, 16'h0100, 16'h0);
        tick();
        drive_nop();
        check_eq("t6_req", dmem_req_o, 1);
        tick();
        reset_i = 1'b1;
        tick();
        reset_i      = 1'b0;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'hBAD0;
        check_eq("t6_req_rst", dmem_req_o, 0);
        check_eq("t6_stall_rst", mem_stall_o, 0);
        check_eq("t6_wb_rst", wb_enable_o, 0);
        tick();
        dmem_ack_i = 1'b0;
        check_eq("t6_late_ack_req", dmem_req_o, 0);
        check_eq("t6_late_ack_wb", wb_enable_o, 0);
        check_eq("t6_late_ack_stall", mem_stall_o, 0);
        issue(1'b0, 1'b0, 1'b1, 3'd3, 16'h4242, 16'h0);
        push_wb(3'd3, 16'h4242);
        tick();
        drive_nop();
        check_eq("t6_next_wb_en", wb_enable_o, 1);
        tick();

        // Back-to-back ALU ops, one per cycle
        for (int i = 0; i < 6; i++) begin
            rnd = W'($urandom);
            issue(1'b0, 1'b0, 1'b1, A'(i + 1), rnd, 16'h0);
            push_wb(A'(i + 1), rnd);
            tick();
        end
        drive_nop();
        repeat (3) tick();

        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
